// File: rtl/max_pooling_layer.sv
// max_pooling_layer
//   Streaming 2x2, stride-2 max-pooling stage. Takes a raster-ordered
//   feature-map stream with one pixel per channel on each accepted cycle.
//   It emits one pooled pixel per channel for each complete 2x2 window.
//   A line buffer per channel holds the horizontal pair maxima of each even row.
//   A trailing odd column or row is counted but is never pooled.
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset; it wins over clk_en
//   clk_en      global stall; when 0, all state and outputs hold
//   in_valid    input_data carries a pixel (accept = clk_en & in_valid)
//   input_data  channel c in bits [D_WIDTH*(c+1)-1 : D_WIDTH*c], signed
//   output_data pooled pixel, same packing; registered, holds between events
//   out_valid   high for one enabled cycle per pooled pixel
//   out_last    high with out_valid on the final pooled pixel of a frame
module max_pooling_layer #(
  parameter int D_WIDTH    = -1,
  parameter int CHANNELS   = -1,
  parameter int IMAGE_SIZE = -1,
  // Clamped copies keep elaboration legal if a parameter is left at its default.
  localparam int DW  = (D_WIDTH < 2) ? 2 : D_WIDTH,
  localparam int CH  = (CHANNELS < 1) ? 1 : CHANNELS,
  localparam int IMG = (IMAGE_SIZE < 2) ? 2 : IMAGE_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              in_valid,
  input  logic [DW*CH-1:0]  input_data,
  output logic [DW*CH-1:0]  output_data,
  output logic              out_valid,
  output logic              out_last
);

  localparam int CW = $clog2(IMG);
  localparam int P  = IMG / 2;
  localparam int IW = (P > 1) ? $clog2(P) : 1;
  localparam int LB = 1 << IW;

  localparam logic [CW-1:0] COORD_LAST = CW'(IMG - 1);
  localparam logic [CW-1:0] POOL_LAST  = CW'(2 * P - 1);
  localparam logic [CW:0]   POOL_LIM   = (CW + 1)'(2 * P);

  function automatic logic signed [DW-1:0] f_smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0]        r_col;
  logic [CW-1:0]        r_row;
  logic signed [DW-1:0] r_hold    [CH];
  logic signed [DW-1:0] r_linebuf [CH][LB];
  logic [DW*CH-1:0]     r_out_data;
  logic                 r_out_valid;
  logic                 r_out_last;

  logic                 w_accept;
  logic                 w_col_last;
  logic                 w_row_last;
  logic                 w_in_pool;
  logic                 w_pool_last;
  logic [IW-1:0]        w_lb_idx;
  logic signed [DW-1:0] w_pix  [CH];
  logic signed [DW-1:0] w_pair [CH];
  logic signed [DW-1:0] w_pool [CH];

  assign w_accept    = clk_en & in_valid;
  assign w_col_last  = (r_col == COORD_LAST);
  assign w_row_last  = (r_row == COORD_LAST);
  assign w_in_pool   = ({1'b0, r_col} < POOL_LIM) && ({1'b0, r_row} < POOL_LIM);
  assign w_pool_last = (r_col == POOL_LAST) && (r_row == POOL_LAST);
  // Any column that reaches the line buffer is < 2P, so col>>1 fits in IW bits.
  assign w_lb_idx    = IW'(r_col >> 1);

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      w_pix[c]  = input_data[c*DW +: DW];
      w_pair[c] = f_smax(r_hold[c], w_pix[c]);
      w_pool[c] = f_smax(w_pair[c], r_linebuf[c][w_lb_idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      for (int c = 0; c < CH; c++) r_hold[c] <= '0;
    end else if (clk_en) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      if (in_valid) begin
        r_col <= w_col_last ? '0 : r_col + 1'b1;
        if (w_col_last) r_row <= w_row_last ? '0 : r_row + 1'b1;
        // The left pixel of every pair is held, on both even and odd rows.
        if (!r_col[0]) begin
          for (int c = 0; c < CH; c++) r_hold[c] <= w_pix[c];
        end
        if (w_in_pool && r_col[0] && r_row[0]) begin
          for (int c = 0; c < CH; c++) r_out_data[c*DW +: DW] <= w_pool[c];
          r_out_valid <= 1'b1;
          r_out_last  <= w_pool_last;
        end
      end
    end
  end

  // The line buffer needs no reset: every entry is written on an even row
  // before the odd row below it reads that entry.
  always_ff @(posedge clk) begin
    if (!rst && w_accept && w_in_pool && r_col[0] && !r_row[0]) begin
      for (int c = 0; c < CH; c++) r_linebuf[c][w_lb_idx] <= w_pair[c];
    end
  end

  assign output_data = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;

endmodule

// File: tb/tb_max_pooling_layer.sv
module tb_max_pooling_layer;

  logic        clk, rst, clk_en;
  logic        in_valid_a, in_valid_b;
  logic [15:0] in_data_a;
  logic [7:0]  in_data_b;
  logic [15:0] out_data_a;
  logic [7:0]  out_data_b;
  logic        out_valid_a, out_last_a, out_valid_b, out_last_b;

  int nvec = 0;
  int nmis = 0;

  // DUT A: 2 channels, 4x4 image.  DUT B: 1 channel, 5x5 image.
  max_pooling_layer #(.D_WIDTH(8), .CHANNELS(2), .IMAGE_SIZE(4)) dut_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(in_valid_a),
    .input_data(in_data_a), .output_data(out_data_a),
    .out_valid(out_valid_a), .out_last(out_last_a));

  max_pooling_layer #(.D_WIDTH(8), .CHANNELS(1), .IMAGE_SIZE(5)) dut_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(in_valid_b),
    .input_data(in_data_b), .output_data(out_data_b),
    .out_valid(out_valid_b), .out_last(out_last_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted pixel is stored in a frame image at its raster position
  // (from the accept count). When the pixel completes a 2x2 window, the
  // expected output is the max of the four stored pixels.
  int nsz[2] = '{4, 5};
  int nch[2] = '{2, 1};
  int mk[2];
  int mfr[2][2][5][5];
  bit mev[2], mel[2];
  int med[2][2];

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_step(input int d, input bit rs, input bit en, input bit v,
                            input logic [15:0] data);
    int n, r, c, p2;
    logic [15:0] dv;
    logic [7:0] s;
    if (rs) begin
      mk[d] = 0; mev[d] = 0; mel[d] = 0; med[d][0] = 0; med[d][1] = 0;
    end else if (en) begin
      mev[d] = 0; mel[d] = 0;
      if (v) begin
        n  = nsz[d];
        r  = mk[d] / n;
        c  = mk[d] % n;
        p2 = (n / 2) * 2;
        dv = data;
        for (int ch = 0; ch < nch[d]; ch++) begin
          s = dv[ch*8 +: 8];
          mfr[d][ch][r][c] = int'($signed(s));
        end
        if ((r % 2 == 1) && (c % 2 == 1) && r < p2 && c < p2) begin
          mev[d] = 1;
          mel[d] = (r == p2 - 1) && (c == p2 - 1);
          for (int ch = 0; ch < nch[d]; ch++)
            med[d][ch] = imax(imax(mfr[d][ch][r-1][c-1], mfr[d][ch][r-1][c]),
                              imax(mfr[d][ch][r][c-1], mfr[d][ch][r][c]));
        end
        mk[d] = (mk[d] + 1) % (n * n);
      end
    end
  endtask

  // captured output events for hand-computed literal checks
  int qa0[$], qa1[$], qal[$], qb0[$], qbl[$];

  // compare process: update model from inputs at the edge, check #1 later
  initial begin
    bit rs, en, va, vb;
    logic [15:0] da;
    logic [7:0] db;
    forever begin
      @(posedge clk);
      rs = rst; en = clk_en; va = in_valid_a; vb = in_valid_b; da = in_data_a; db = in_data_b;
      model_step(0, rs, en, va, da);
      model_step(1, rs, en, vb, {8'h00, db});
      #1;
      chk("A out_valid", int'(out_valid_a), int'(mev[0]));
      chk("A out_last",  int'(out_last_a),  int'(mel[0]));
      chk("A data ch0",  int'($signed(out_data_a[7:0])),  med[0][0]);
      chk("A data ch1",  int'($signed(out_data_a[15:8])), med[0][1]);
      chk("B out_valid", int'(out_valid_b), int'(mev[1]));
      chk("B out_last",  int'(out_last_b),  int'(mel[1]));
      chk("B data",      int'($signed(out_data_b)), med[1][0]);
      if (!rs && en && out_valid_a) begin
        qa0.push_back(int'($signed(out_data_a[7:0])));
        qa1.push_back(int'($signed(out_data_a[15:8])));
        qal.push_back(int'(out_last_a));
      end
      if (!rs && en && out_valid_b) begin
        qb0.push_back(int'($signed(out_data_b)));
        qbl.push_back(int'(out_last_b));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_a(input int v0, input int v1);
    logic [7:0] b0, b1;
    b0 = v0[7:0]; b1 = v1[7:0];
    in_valid_a = 1'b1; in_data_a = {b1, b0};
    @(negedge clk);
  endtask

  task automatic send_b(input int v0);
    in_valid_b = 1'b1; in_data_b = v0[7:0];
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_a(input string nm, input int n, input int e0[8], input int e1[8],
                         input int lmask);
    chk({nm, " count"}, qa0.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < qa0.size()) begin
        chk({nm, " ch0"},  qa0[i], e0[i]);
        chk({nm, " ch1"},  qa1[i], e1[i]);
        chk({nm, " last"}, qal[i], (lmask >> i) & 1);
      end
    end
    qa0.delete(); qa1.delete(); qal.delete();
  endtask

  task automatic check_b(input string nm, input int n, input int e0[8], input int lmask);
    chk({nm, " count"}, qb0.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < qb0.size()) begin
        chk({nm, " val"},  qb0[i], e0[i]);
        chk({nm, " last"}, qbl[i], (lmask >> i) & 1);
      end
    end
    qb0.delete(); qbl.delete();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1; clk_en = 1'b1;
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_data_a = '0; in_data_b = '0;
    repeat (2) @(negedge clk);
    chk("reset valid", int'(out_valid_a), 0);
    chk("reset data",  int'(out_data_a), 0);
    rst = 1'b0;

    // 1: ramp 0..15, ch1 = 100 - ch0
    for (int p = 0; p < 16; p++) send_a(p, 100 - p);
    idle(2);
    check_a("ramp", 4, '{5, 7, 13, 15, 0, 0, 0, 0}, '{100, 98, 92, 90, 0, 0, 0, 0}, 8);

    // 2: negated ramp, signed max
    for (int p = 0; p < 16; p++) send_a(-p, 100 + p);
    idle(2);
    check_a("neg", 4, '{0, -2, -8, -10, 0, 0, 0, 0}, '{105, 107, 113, 115, 0, 0, 0, 0}, 8);

    // 2b: -128 against 0, and -127 against -128
    for (int p = 0; p < 16; p++) send_a((p % 2 == 0) ? 0 : -128, (p == 5) ? -127 : -128);
    idle(2);
    check_a("min", 4, '{0, 0, 0, 0, 0, 0, 0, 0}, '{-127, -128, -128, -128, 0, 0, 0, 0}, 8);

    // 3: 5x5 image, trailing column/row dropped
    for (int p = 0; p < 25; p++) send_b(p);
    idle(2);
    check_b("odd", 4, '{6, 8, 16, 18, 0, 0, 0, 0}, 8);

    // 4: random gaps plus a 3-cycle stall with in_valid high mid-row
    for (int p = 0; p < 16; p++) begin
      if (p == 6) begin
        clk_en = 1'b0;
        in_valid_a = 1'b1; in_data_a = {8'(100 - 6), 8'd6};
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall valid hold", int'(out_valid_a), 1);
          chk("stall data hold",  int'($signed(out_data_a[7:0])), 5);
        end
        clk_en = 1'b1;
      end else begin
        idle($urandom_range(0, 2));
      end
      send_a(p, 100 - p);
    end
    idle(2);
    check_a("gaps", 4, '{5, 7, 13, 15, 0, 0, 0, 0}, '{100, 98, 92, 90, 0, 0, 0, 0}, 8);

    // 5: reset mid-frame (with clk_en low), then a clean frame
    for (int p = 0; p < 6; p++) send_a(p + 50, 7);
    rst = 1'b1; clk_en = 1'b0; in_valid_a = 1'b1; in_data_a = 16'h6363;
    @(negedge clk);
    chk("midrst valid", int'(out_valid_a), 0);
    chk("midrst data",  int'(out_data_a), 0);
    rst = 1'b0; clk_en = 1'b1; in_valid_a = 1'b0;
    qa0.delete(); qa1.delete(); qal.delete();
    for (int p = 0; p < 16; p++) send_a(p, 100 - p);
    idle(2);
    check_a("postrst", 4, '{5, 7, 13, 15, 0, 0, 0, 0}, '{100, 98, 92, 90, 0, 0, 0, 0}, 8);

    // 6: two frames back to back
    for (int p = 0; p < 16; p++) send_a(p, 100 - p);
    for (int p = 0; p < 16; p++) send_a(p + 20, 80 - p);
    idle(2);
    check_a("b2b", 8, '{5, 7, 13, 15, 25, 27, 33, 35}, '{100, 98, 92, 90, 80, 78, 72, 70}, 136);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
